// File: rtl/axi_addr_router.sv
// Purpose: 1-to-2 AXI address router; one base/mask window selects s0, everything else goes to s1.
// Latency: AW/AR add 1 cycle (registered capture); W, B and R are combinational pass-through.
// Backpressure: one transaction per direction; a stalled target stalls only its own direction.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   master_*          upstream AXI port (this block is the slave)
//   s0_*              window target, chosen when (addr & S0_MASK) == S0_BASE
//   s1_*              default target (typically a DECERR responder)
module axi_addr_router #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ID_WIDTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] S0_BASE    = '0,
  parameter logic [ADDR_WIDTH-1:0] S0_MASK    = '0
) (
  input  logic                    clk,
  input  logic                    rstn,
  // master: AW
  input  logic                    master_aw_valid,
  output logic                    master_aw_ready,
  input  logic [ID_WIDTH-1:0]     master_aw_id,
  input  logic [ADDR_WIDTH-1:0]   master_aw_addr,
  input  logic [7:0]              master_aw_len,
  input  logic [2:0]              master_aw_size,
  input  logic [1:0]              master_aw_burst,
  // master: W
  input  logic                    master_w_valid,
  output logic                    master_w_ready,
  input  logic [DATA_WIDTH-1:0]   master_w_data,
  input  logic [DATA_WIDTH/8-1:0] master_w_strb,
  input  logic                    master_w_last,
  // master: B
  output logic                    master_b_valid,
  input  logic                    master_b_ready,
  output logic [ID_WIDTH-1:0]     master_b_id,
  output logic [1:0]              master_b_resp,
  // master: AR
  input  logic                    master_ar_valid,
  output logic                    master_ar_ready,
  input  logic [ID_WIDTH-1:0]     master_ar_id,
  input  logic [ADDR_WIDTH-1:0]   master_ar_addr,
  input  logic [7:0]              master_ar_len,
  input  logic [2:0]              master_ar_size,
  input  logic [1:0]              master_ar_burst,
  // master: R
  output logic                    master_r_valid,
  input  logic                    master_r_ready,
  output logic [ID_WIDTH-1:0]     master_r_id,
  output logic [DATA_WIDTH-1:0]   master_r_data,
  output logic [1:0]              master_r_resp,
  output logic                    master_r_last,
  // s0: AW / W / B
  output logic                    s0_aw_valid,
  input  logic                    s0_aw_ready,
  output logic [ID_WIDTH-1:0]     s0_aw_id,
  output logic [ADDR_WIDTH-1:0]   s0_aw_addr,
  output logic [7:0]              s0_aw_len,
  output logic [2:0]              s0_aw_size,
  output logic [1:0]              s0_aw_burst,
  output logic                    s0_w_valid,
  input  logic                    s0_w_ready,
  output logic [DATA_WIDTH-1:0]   s0_w_data,
  output logic [DATA_WIDTH/8-1:0] s0_w_strb,
  output logic                    s0_w_last,
  input  logic                    s0_b_valid,
  output logic                    s0_b_ready,
  input  logic [ID_WIDTH-1:0]     s0_b_id,
  input  logic [1:0]              s0_b_resp,
  // s0: AR / R
  output logic                    s0_ar_valid,
  input  logic                    s0_ar_ready,
  output logic [ID_WIDTH-1:0]     s0_ar_id,
  output logic [ADDR_WIDTH-1:0]   s0_ar_addr,
  output logic [7:0]              s0_ar_len,
  output logic [2:0]              s0_ar_size,
  output logic [1:0]              s0_ar_burst,
  input  logic                    s0_r_valid,
  output logic                    s0_r_ready,
  input  logic [ID_WIDTH-1:0]     s0_r_id,
  input  logic [DATA_WIDTH-1:0]   s0_r_data,
  input  logic [1:0]              s0_r_resp,
  input  logic                    s0_r_last,
  // s1: AW / W / B
  output logic                    s1_aw_valid,
  input  logic                    s1_aw_ready,
  output logic [ID_WIDTH-1:0]     s1_aw_id,
  output logic [ADDR_WIDTH-1:0]   s1_aw_addr,
  output logic [7:0]              s1_aw_len,
  output logic [2:0]              s1_aw_size,
  output logic [1:0]              s1_aw_burst,
  output logic                    s1_w_valid,
  input  logic                    s1_w_ready,
  output logic [DATA_WIDTH-1:0]   s1_w_data,
  output logic [DATA_WIDTH/8-1:0] s1_w_strb,
  output logic                    s1_w_last,
  input  logic                    s1_b_valid,
  output logic                    s1_b_ready,
  input  logic [ID_WIDTH-1:0]     s1_b_id,
  input  logic [1:0]              s1_b_resp,
  // s1: AR / R
  output logic                    s1_ar_valid,
  input  logic                    s1_ar_ready,
  output logic [ID_WIDTH-1:0]     s1_ar_id,
  output logic [ADDR_WIDTH-1:0]   s1_ar_addr,
  output logic [7:0]              s1_ar_len,
  output logic [2:0]              s1_ar_size,
  output logic [1:0]              s1_ar_burst,
  input  logic                    s1_r_valid,
  output logic                    s1_r_ready,
  input  logic [ID_WIDTH-1:0]     s1_r_id,
  input  logic [DATA_WIDTH-1:0]   s1_r_data,
  input  logic [1:0]              s1_r_resp,
  input  logic                    s1_r_last
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  // sel: 0 = s0 (window hit), 1 = s1 (miss); frozen for the whole transaction
  logic w_sel, r_sel;
  logic aw_capture, ar_capture;
  logic aw_hit, ar_hit;

  logic [ID_WIDTH-1:0]   aw_id_q,    ar_id_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q,  ar_addr_q;
  logic [7:0]            aw_len_q,   ar_len_q;
  logic [2:0]            aw_size_q,  ar_size_q;
  logic [1:0]            aw_burst_q, ar_burst_q;

  assign aw_hit     = (master_aw_addr & S0_MASK) == S0_BASE;
  assign ar_hit     = (master_ar_addr & S0_MASK) == S0_BASE;
  assign aw_capture = (w_state == W_IDLE) && master_aw_valid;
  assign ar_capture = (r_state == R_IDLE) && master_ar_valid;

  // ---------------------------------------------------------------- write path
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      w_sel   <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      if (aw_capture) w_sel <= ~aw_hit;
    end
  end

  // Payload is only meaningful while the FSM is past IDLE, so it carries no reset.
  always_ff @(posedge clk) begin
    if (aw_capture) begin
      aw_id_q    <= master_aw_id;
      aw_addr_q  <= master_aw_addr;
      aw_len_q   <= master_aw_len;
      aw_size_q  <= master_aw_size;
      aw_burst_q <= master_aw_burst;
    end
  end

  // Address/data fields are broadcast; only the valids are steered.
  assign s0_aw_id    = aw_id_q;
  assign s0_aw_addr  = aw_addr_q;
  assign s0_aw_len   = aw_len_q;
  assign s0_aw_size  = aw_size_q;
  assign s0_aw_burst = aw_burst_q;
  assign s1_aw_id    = aw_id_q;
  assign s1_aw_addr  = aw_addr_q;
  assign s1_aw_len   = aw_len_q;
  assign s1_aw_size  = aw_size_q;
  assign s1_aw_burst = aw_burst_q;
  assign s0_w_data   = master_w_data;
  assign s0_w_strb   = master_w_strb;
  assign s0_w_last   = master_w_last;
  assign s1_w_data   = master_w_data;
  assign s1_w_strb   = master_w_strb;
  assign s1_w_last   = master_w_last;

  always_comb begin
    w_state_nxt     = w_state;
    master_aw_ready = 1'b0;
    master_w_ready  = 1'b0;
    master_b_valid  = 1'b0;
    master_b_id     = '0;
    master_b_resp   = 2'b00;
    s0_aw_valid     = 1'b0;
    s1_aw_valid     = 1'b0;
    s0_w_valid      = 1'b0;
    s1_w_valid      = 1'b0;
    s0_b_ready      = 1'b0;
    s1_b_ready      = 1'b0;
    case (w_state)
      W_IDLE: begin
        master_aw_ready = 1'b1;
        if (master_aw_valid) w_state_nxt = W_ADDR;
      end
      W_ADDR: begin
        s0_aw_valid = ~w_sel;
        s1_aw_valid = w_sel;
        if (w_sel ? s1_aw_ready : s0_aw_ready) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        if (w_sel) begin
          s1_w_valid     = master_w_valid;
          master_w_ready = s1_w_ready;
        end else begin
          s0_w_valid     = master_w_valid;
          master_w_ready = s0_w_ready;
        end
        if (master_w_valid && master_w_ready && master_w_last) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        if (w_sel) begin
          master_b_valid = s1_b_valid;
          master_b_id    = s1_b_id;
          master_b_resp  = s1_b_resp;
          s1_b_ready     = master_b_ready;
        end else begin
          master_b_valid = s0_b_valid;
          master_b_id    = s0_b_id;
          master_b_resp  = s0_b_resp;
          s0_b_ready     = master_b_ready;
        end
        if (master_b_valid && master_b_ready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- read path
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= R_IDLE;
      r_sel   <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      if (ar_capture) r_sel <= ~ar_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (ar_capture) begin
      ar_id_q    <= master_ar_id;
      ar_addr_q  <= master_ar_addr;
      ar_len_q   <= master_ar_len;
      ar_size_q  <= master_ar_size;
      ar_burst_q <= master_ar_burst;
    end
  end

  assign s0_ar_id    = ar_id_q;
  assign s0_ar_addr  = ar_addr_q;
  assign s0_ar_len   = ar_len_q;
  assign s0_ar_size  = ar_size_q;
  assign s0_ar_burst = ar_burst_q;
  assign s1_ar_id    = ar_id_q;
  assign s1_ar_addr  = ar_addr_q;
  assign s1_ar_len   = ar_len_q;
  assign s1_ar_size  = ar_size_q;
  assign s1_ar_burst = ar_burst_q;

  always_comb begin
    r_state_nxt     = r_state;
    master_ar_ready = 1'b0;
    master_r_valid  = 1'b0;
    master_r_id     = '0;
    master_r_data   = '0;
    master_r_resp   = 2'b00;
    master_r_last   = 1'b0;
    s0_ar_valid     = 1'b0;
    s1_ar_valid     = 1'b0;
    s0_r_ready      = 1'b0;
    s1_r_ready      = 1'b0;
    case (r_state)
      R_IDLE: begin
        master_ar_ready = 1'b1;
        if (master_ar_valid) r_state_nxt = R_ADDR;
      end
      R_ADDR: begin
        s0_ar_valid = ~r_sel;
        s1_ar_valid = r_sel;
        if (r_sel ? s1_ar_ready : s0_ar_ready) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        // The unselected port's r_valid is ignored and its r_ready stays low.
        if (r_sel) begin
          master_r_valid = s1_r_valid;
          master_r_id    = s1_r_id;
          master_r_data  = s1_r_data;
          master_r_resp  = s1_r_resp;
          master_r_last  = s1_r_last;
          s1_r_ready     = master_r_ready;
        end else begin
          master_r_valid = s0_r_valid;
          master_r_id    = s0_r_id;
          master_r_data  = s0_r_data;
          master_r_resp  = s0_r_resp;
          master_r_last  = s0_r_last;
          s0_r_ready     = master_r_ready;
        end
        if (master_r_valid && master_r_ready && master_r_last) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_addr_router.sv
module tb_axi_addr_router;

  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // master side
  logic        m_aw_valid, m_w_valid, m_w_last, m_b_ready, m_ar_valid, m_r_ready;
  logic [3:0]  m_aw_id, m_ar_id;
  logic [63:0] m_aw_addr, m_ar_addr, m_w_data;
  logic [7:0]  m_aw_len, m_ar_len, m_w_strb;
  logic [2:0]  m_aw_size, m_ar_size;
  logic [1:0]  m_aw_burst, m_ar_burst;
  wire         m_aw_ready, m_w_ready, m_b_valid, m_ar_ready, m_r_valid, m_r_last;
  wire  [3:0]  m_b_id, m_r_id;
  wire  [1:0]  m_b_resp, m_r_resp;
  wire  [63:0] m_r_data;

  // slave side, index 0 = s0, 1 = s1
  logic [1:0]  sl_aw_ready, sl_w_ready, sl_b_valid, sl_ar_ready, sl_r_valid, sl_r_last;
  logic [3:0]  sl_b_id [2];
  logic [1:0]  sl_b_resp [2];
  logic [3:0]  sl_r_id [2];
  logic [63:0] sl_r_data [2];
  logic [1:0]  sl_r_resp [2];
  wire  [1:0]  s_aw_valid, s_w_valid, s_w_last, s_b_ready, s_ar_valid, s_r_ready;
  wire  [63:0] s_aw_addr [2];
  wire  [3:0]  s_aw_id [2];
  wire  [7:0]  s_aw_len [2];
  wire  [2:0]  s_aw_size [2];
  wire  [1:0]  s_aw_burst [2];
  wire  [63:0] s_w_data [2];
  wire  [7:0]  s_w_strb [2];
  wire  [63:0] s_ar_addr [2];
  wire  [3:0]  s_ar_id [2];
  wire  [7:0]  s_ar_len [2];
  wire  [2:0]  s_ar_size [2];
  wire  [1:0]  s_ar_burst [2];

  axi_addr_router #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_WIDTH(4),
    .S0_BASE(64'h0000_0000_1000_0000), .S0_MASK(64'h0000_0000_F000_0000)
  ) dut (
    .clk(clk), .rstn(rstn),
    .master_aw_valid(m_aw_valid), .master_aw_ready(m_aw_ready), .master_aw_id(m_aw_id),
    .master_aw_addr(m_aw_addr), .master_aw_len(m_aw_len), .master_aw_size(m_aw_size),
    .master_aw_burst(m_aw_burst),
    .master_w_valid(m_w_valid), .master_w_ready(m_w_ready), .master_w_data(m_w_data),
    .master_w_strb(m_w_strb), .master_w_last(m_w_last),
    .master_b_valid(m_b_valid), .master_b_ready(m_b_ready), .master_b_id(m_b_id),
    .master_b_resp(m_b_resp),
    .master_ar_valid(m_ar_valid), .master_ar_ready(m_ar_ready), .master_ar_id(m_ar_id),
    .master_ar_addr(m_ar_addr), .master_ar_len(m_ar_len), .master_ar_size(m_ar_size),
    .master_ar_burst(m_ar_burst),
    .master_r_valid(m_r_valid), .master_r_ready(m_r_ready), .master_r_id(m_r_id),
    .master_r_data(m_r_data), .master_r_resp(m_r_resp), .master_r_last(m_r_last),
    .s0_aw_valid(s_aw_valid[0]), .s0_aw_ready(sl_aw_ready[0]), .s0_aw_id(s_aw_id[0]),
    .s0_aw_addr(s_aw_addr[0]), .s0_aw_len(s_aw_len[0]), .s0_aw_size(s_aw_size[0]),
    .s0_aw_burst(s_aw_burst[0]),
    .s0_w_valid(s_w_valid[0]), .s0_w_ready(sl_w_ready[0]), .s0_w_data(s_w_data[0]),
    .s0_w_strb(s_w_strb[0]), .s0_w_last(s_w_last[0]),
    .s0_b_valid(sl_b_valid[0]), .s0_b_ready(s_b_ready[0]), .s0_b_id(sl_b_id[0]),
    .s0_b_resp(sl_b_resp[0]),
    .s0_ar_valid(s_ar_valid[0]), .s0_ar_ready(sl_ar_ready[0]), .s0_ar_id(s_ar_id[0]),
    .s0_ar_addr(s_ar_addr[0]), .s0_ar_len(s_ar_len[0]), .s0_ar_size(s_ar_size[0]),
    .s0_ar_burst(s_ar_burst[0]),
    .s0_r_valid(sl_r_valid[0]), .s0_r_ready(s_r_ready[0]), .s0_r_id(sl_r_id[0]),
    .s0_r_data(sl_r_data[0]), .s0_r_resp(sl_r_resp[0]), .s0_r_last(sl_r_last[0]),
    .s1_aw_valid(s_aw_valid[1]), .s1_aw_ready(sl_aw_ready[1]), .s1_aw_id(s_aw_id[1]),
    .s1_aw_addr(s_aw_addr[1]), .s1_aw_len(s_aw_len[1]), .s1_aw_size(s_aw_size[1]),
    .s1_aw_burst(s_aw_burst[1]),
    .s1_w_valid(s_w_valid[1]), .s1_w_ready(sl_w_ready[1]), .s1_w_data(s_w_data[1]),
    .s1_w_strb(s_w_strb[1]), .s1_w_last(s_w_last[1]),
    .s1_b_valid(sl_b_valid[1]), .s1_b_ready(s_b_ready[1]), .s1_b_id(sl_b_id[1]),
    .s1_b_resp(sl_b_resp[1]),
    .s1_ar_valid(s_ar_valid[1]), .s1_ar_ready(sl_ar_ready[1]), .s1_ar_id(s_ar_id[1]),
    .s1_ar_addr(s_ar_addr[1]), .s1_ar_len(s_ar_len[1]), .s1_ar_size(s_ar_size[1]),
    .s1_ar_burst(s_ar_burst[1]),
    .s1_r_valid(sl_r_valid[1]), .s1_r_ready(s_r_ready[1]), .s1_r_id(sl_r_id[1]),
    .s1_r_data(sl_r_data[1]), .s1_r_resp(sl_r_resp[1]), .s1_r_last(sl_r_last[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------ slave models
  // s0 answers OKAY, read data 0x5000+beat; s1 behaves as a DECERR dummy slave, data 0xDEAD.
  logic        wtog;
  int          aw_cnt [2], aw_cyc [2], awv_cyc [2], wv_cyc [2], arv_cyc [2], wcnt [2];
  logic [63:0] aw_addr_cap [2];
  logic [7:0]  aw_len_cap [2];
  logic [63:0] wbuf [2][32];
  logic        wlbuf [2][32];
  logic        b_pend [2], r_busy [2];
  logic [3:0]  bid_q [2], rid_q [2];
  int          r_beat [2], r_len [2];

  initial begin
    wtog = 1'b0;
    for (int p = 0; p < 2; p++) begin
      aw_cnt[p] = 0; aw_cyc[p] = 0; awv_cyc[p] = 0; wv_cyc[p] = 0; arv_cyc[p] = 0; wcnt[p] = 0;
      b_pend[p] = 1'b0; r_busy[p] = 1'b0; bid_q[p] = '0; rid_q[p] = '0; r_beat[p] = 0; r_len[p] = 0;
    end
  end

  initial begin
    sl_aw_ready = '0; sl_w_ready = '0; sl_b_valid = '0; sl_ar_ready = '0; sl_r_valid = '0;
    sl_r_last = '0;
    for (int p = 0; p < 2; p++) begin
      sl_b_id[p] = '0; sl_b_resp[p] = '0; sl_r_id[p] = '0; sl_r_data[p] = '0; sl_r_resp[p] = '0;
    end
    forever begin
      @(negedge clk);
      if (!rstn) begin
        sl_aw_ready = '0; sl_w_ready = '0; sl_b_valid = '0; sl_ar_ready = '0; sl_r_valid = '0;
        sl_r_last = '0;
        for (int p = 0; p < 2; p++) begin
          b_pend[p] = 1'b0; r_busy[p] = 1'b0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          sl_aw_ready[p] = 1'b1;
          sl_ar_ready[p] = ~r_busy[p];
          sl_w_ready[p]  = (p == 0 && wtog) ? ~sl_w_ready[p] : 1'b1;
          sl_b_valid[p]  = b_pend[p];
          sl_b_id[p]     = bid_q[p];
          sl_b_resp[p]   = (p == 0) ? 2'b00 : 2'b11;
          sl_r_valid[p]  = r_busy[p];
          sl_r_id[p]     = rid_q[p];
          sl_r_data[p]   = (p == 0) ? 64'h5000 + 64'(r_beat[p]) : 64'hDEAD;
          sl_r_resp[p]   = (p == 0) ? 2'b00 : 2'b11;
          sl_r_last[p]   = r_busy[p] && (r_beat[p] == r_len[p]);
        end
        #1;
        for (int p = 0; p < 2; p++) begin
          awv_cyc[p] += int'(s_aw_valid[p]);
          wv_cyc[p]  += int'(s_w_valid[p]);
          arv_cyc[p] += int'(s_ar_valid[p]);
          if (s_aw_valid[p] && sl_aw_ready[p]) begin
            aw_cnt[p]++;
            aw_cyc[p]      = cyc;
            aw_addr_cap[p] = s_aw_addr[p];
            aw_len_cap[p]  = s_aw_len[p];
            bid_q[p]       = s_aw_id[p];
          end
          if (sl_b_valid[p] && s_b_ready[p]) b_pend[p] = 1'b0;
          if (s_w_valid[p] && sl_w_ready[p]) begin
            if (wcnt[p] < 32) begin
              wbuf[p][wcnt[p]]  = s_w_data[p];
              wlbuf[p][wcnt[p]] = s_w_last[p];
            end
            wcnt[p]++;
            if (s_w_last[p]) b_pend[p] = 1'b1;
          end
          if (sl_r_valid[p] && s_r_ready[p]) begin
            if (r_beat[p] == r_len[p]) r_busy[p] = 1'b0;
            else r_beat[p]++;
          end
          if (s_ar_valid[p] && sl_ar_ready[p]) begin
            r_busy[p] = 1'b1;
            r_beat[p] = 0;
            r_len[p]  = int'(s_ar_len[p]);
            rid_q[p]  = s_ar_id[p];
          end
        end
      end
    end
  end

  // ------------------------------------------------------------ master tasks
  int   aw_hs_cyc;
  logic aw_done, early_rdy;

  task automatic m_write(input logic [63:0] addr, input logic [3:0] id, input int len,
                         input logic [63:0] dbase, input int aw_delay, input int b_hold,
                         output logic [3:0] bid, output logic [1:0] bresp);
    int to;
    aw_done   = 1'b0;
    early_rdy = 1'b0;
    fork
      begin
        int ta;
        repeat (aw_delay) @(negedge clk);
        @(negedge clk);
        m_aw_valid = 1'b1; m_aw_addr = addr; m_aw_id = id; m_aw_len = len[7:0];
        m_aw_size = 3'd3; m_aw_burst = 2'd1;
        #1; ta = 0;
        while (!m_aw_ready && ta < TMO) begin @(negedge clk); #1; ta++; end
        chk("aw_handshake", 64'(ta < TMO), 64'd1);
        aw_hs_cyc = cyc;
        @(negedge clk);
        m_aw_valid = 1'b0;
        aw_done    = 1'b1;
      end
      begin
        int tw;
        for (int i = 0; i <= len; i++) begin
          @(negedge clk);
          m_w_valid = 1'b1; m_w_data = dbase + 64'(i); m_w_strb = 8'hFF; m_w_last = (i == len);
          #1; tw = 0;
          while (!m_w_ready && tw < TMO) begin @(negedge clk); #1; tw++; end
          if (!aw_done && m_w_ready) early_rdy = 1'b1;
          chk("w_handshake", 64'(tw < TMO), 64'd1);
        end
        @(negedge clk);
        m_w_valid = 1'b0; m_w_last = 1'b0;
      end
    join
    #1; to = 0;
    while (!m_b_valid && to < TMO) begin @(negedge clk); #1; to++; end
    chk("b_wait", 64'(to < TMO), 64'd1);
    for (int k = 0; k < b_hold; k++) begin
      chk($sformatf("b_hold_valid%0d", k), 64'(m_b_valid), 64'd1);
      chk($sformatf("b_hold_aw_ready%0d", k), 64'(m_aw_ready), 64'd0);
      @(negedge clk); #1;
    end
    m_b_ready = 1'b1;
    #1;
    bid   = m_b_id;
    bresp = m_b_resp;
    @(negedge clk);
    m_b_ready = 1'b0;
    #1;
    chk("aw_ready_after_b", 64'(m_aw_ready), 64'd1);
  endtask

  task automatic m_read(input logic [63:0] addr, input logic [3:0] id, input int len,
                        input logic [63:0] dbase, input logic inc, input logic [1:0] resp,
                        input int nbeats);
    int to;
    @(negedge clk);
    m_ar_valid = 1'b1; m_ar_addr = addr; m_ar_id = id; m_ar_len = len[7:0];
    m_ar_size = 3'd3; m_ar_burst = 2'd1;
    #1; to = 0;
    while (!m_ar_ready && to < TMO) begin @(negedge clk); #1; to++; end
    chk("ar_handshake", 64'(to < TMO), 64'd1);
    @(negedge clk);
    m_ar_valid = 1'b0;
    m_r_ready  = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      #1; to = 0;
      while (!m_r_valid && to < TMO) begin @(negedge clk); #1; to++; end
      chk($sformatf("r_wait%0d", i), 64'(to < TMO), 64'd1);
      chk($sformatf("r_data%0d", i), m_r_data, inc ? dbase + 64'(i) : dbase);
      chk($sformatf("r_id%0d", i), 64'(m_r_id), 64'(id));
      chk($sformatf("r_resp%0d", i), 64'(m_r_resp), 64'(resp));
      chk($sformatf("r_last%0d", i), 64'(m_r_last), 64'(i == len));
      @(negedge clk);
    end
    m_r_ready = 1'b0;
  endtask

  // Everything that must be quiet during reset, packed: master-facing valids/w_ready, then
  // per-port slave-facing valids and readies.
  function automatic logic [12:0] quiet_vec();
    return {m_b_valid, m_r_valid, m_w_ready, s_aw_valid, s_w_valid, s_ar_valid, s_b_ready, s_r_ready};
  endfunction

  // ------------------------------------------------------------ directed tests
  logic [3:0] bid;
  logic [1:0] bresp;
  int         s0w, s1awv, s1wv, s0arv;

  initial begin
    rstn = 1'b0;
    m_aw_valid = 0; m_aw_id = 0; m_aw_addr = 0; m_aw_len = 0; m_aw_size = 0; m_aw_burst = 0;
    m_w_valid = 0; m_w_data = 0; m_w_strb = 0; m_w_last = 0; m_b_ready = 0;
    m_ar_valid = 0; m_ar_id = 0; m_ar_addr = 0; m_ar_len = 0; m_ar_size = 0; m_ar_burst = 0;
    m_r_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_quiet", 64'(quiet_vec()), 64'd0);
    chk("rst_aw_ready", 64'(m_aw_ready), 64'd1);
    chk("rst_ar_ready", 64'(m_ar_ready), 64'd1);
    #1 rstn = 1'b1;
    @(negedge clk); #1;
    chk("idle_quiet", 64'(quiet_vec()), 64'd0);

    // hit write, len=3
    s0w = wcnt[0]; s1awv = awv_cyc[1]; s1wv = wv_cyc[1];
    m_write(64'h1000_0040, 4'd3, 3, 64'hA000, 0, 0, bid, bresp);
    chk("t1_aw_latency", 64'(aw_cyc[0] - aw_hs_cyc), 64'd1);
    chk("t1_aw_addr", aw_addr_cap[0], 64'h1000_0040);
    chk("t1_aw_len", 64'(aw_len_cap[0]), 64'd3);
    chk("t1_beats", 64'(wcnt[0] - s0w), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_wdata%0d", i), wbuf[0][s0w + i], 64'hA000 + 64'(i));
      chk($sformatf("t1_wlast%0d", i), 64'(wlbuf[0][s0w + i]), 64'(i == 3));
    end
    chk("t1_s1_aw_quiet", 64'(awv_cyc[1] - s1awv), 64'd0);
    chk("t1_s1_w_quiet", 64'(wv_cyc[1] - s1wv), 64'd0);
    chk("t1_bid", 64'(bid), 64'd3);
    chk("t1_bresp", 64'(bresp), 64'd0);

    // miss read, len=7, to the DECERR responder
    m_read(64'h2000_0000, 4'd5, 7, 64'hDEAD, 1'b0, 2'b11, 8);

    // concurrent: AW hit and AR miss in the same cycle
    s0w = wcnt[0]; s1awv = awv_cyc[1]; s1wv = wv_cyc[1]; s0arv = arv_cyc[0];
    fork
      m_write(64'h1000_0100, 4'd1, 1, 64'hC000, 0, 0, bid, bresp);
      m_read(64'h3000_0000, 4'd2, 1, 64'hDEAD, 1'b0, 2'b11, 2);
    join
    chk("t3_beats", 64'(wcnt[0] - s0w), 64'd2);
    chk("t3_wdata1", wbuf[0][s0w + 1], 64'hC001);
    chk("t3_bid", 64'(bid), 64'd1);
    chk("t3_bresp", 64'(bresp), 64'd0);
    chk("t3_s1_aw_quiet", 64'(awv_cyc[1] - s1awv), 64'd0);
    chk("t3_s1_w_quiet", 64'(wv_cyc[1] - s1wv), 64'd0);
    chk("t3_s0_ar_quiet", 64'(arv_cyc[0] - s0arv), 64'd0);

    // backpressure: toggling w_ready on s0, master holds b_ready low for 5 cycles
    wtog = 1'b1;
    s0w = wcnt[0];
    m_write(64'h1000_0200, 4'd6, 3, 64'hB000, 0, 5, bid, bresp);
    wtog = 1'b0;
    chk("t4_beats", 64'(wcnt[0] - s0w), 64'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t4_wdata%0d", i), wbuf[0][s0w + i], 64'hB000 + 64'(i));
    chk("t4_bid", 64'(bid), 64'd6);

    // W presented two cycles ahead of AW
    s0w = wcnt[0];
    m_write(64'h1000_0300, 4'd7, 0, 64'h11, 2, 0, bid, bresp);
    chk("t5_early_w_ready", 64'(early_rdy), 64'd0);
    chk("t5_beats", 64'(wcnt[0] - s0w), 64'd1);
    chk("t5_wdata", wbuf[0][s0w], 64'h11);
    chk("t5_wlast", 64'(wlbuf[0][s0w]), 64'd1);
    chk("t5_bid", 64'(bid), 64'd7);

    // reset after beat 2 of a len=3 read to s0
    m_read(64'h1000_0400, 4'd4, 3, 64'h5000, 1'b1, 2'b00, 2);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_quiet", 64'(quiet_vec()), 64'd0);
    chk("t6_rst_ar_ready", 64'(m_ar_ready), 64'd1);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    #1;
    chk("t6_post_quiet", 64'(quiet_vec()), 64'd0);
    chk("t6_post_aw_ready", 64'(m_aw_ready), 64'd1);
    chk("t6_post_ar_ready", 64'(m_ar_ready), 64'd1);
    m_read(64'h1000_0500, 4'd8, 1, 64'h5000, 1'b1, 2'b00, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
